// File: rtl/seg7_scan_if.sv
// Scanned 7-segment display bus: segment pattern plus one-hot digit select.
// The display driver is the master; the capture block listens as slave.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [7:0]        segin;
    logic [DIGITS-1:0] digsel;

    modport master (output segin, output digsel);
    modport slave  (input  segin, input  digsel);
endinterface

// File: rtl/seg7_scan_capture.sv
// Rebuilds packed BCD digits from a scanned 7-segment display bus.
// Optional SEG7_DP_EN: treat segin[7] as decimal point and report it on dpout.
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_if.slave          bus,
    output logic [4*DIGITS-1:0] bcdout,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                frame_done,
    output logic                err,
    output logic [7:0]          err_cnt
`ifdef SEG7_DP_EN
    ,
    output logic [DIGITS-1:0]   dpout
`endif
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);
    localparam int         SW         = DIGITS + 8;

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [SW-1:0]            sample_q, sample_d;
    logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]        valid_q, valid_d;
    logic [DIGITS-1:0]        seen_q, seen_d;
    logic [DIGITS-1:0]        dp_q, dp_d;
    logic                     frame_done_q, frame_done_d;
    logic                     err_q, err_d;
    logic [7:0]               err_cnt_q, err_cnt_d;

    logic                     new_onehot;
    logic                     changed;
    logic [DIGITS-1:0]        sel_q;
    logic [7:0]               seg_q;
    logic [7:0]               dec_pat;
    logic [4:0]               dec;

    // {hit, value}; misses report the blank code
    function automatic logic [4:0] decode(input logic [7:0] p);
        case (p)
            8'h7E:   decode = {1'b1, 4'd0};
            8'h30:   decode = {1'b1, 4'd1};
            8'h6D:   decode = {1'b1, 4'd2};
            8'h79:   decode = {1'b1, 4'd3};
            8'h33:   decode = {1'b1, 4'd4};
            8'h5B:   decode = {1'b1, 4'd5};
            8'h5F:   decode = {1'b1, 4'd6};
            8'h70:   decode = {1'b1, 4'd7};
            8'h7F:   decode = {1'b1, 4'd8};
            8'h7B:   decode = {1'b1, 4'd9};
            default: decode = {1'b0, 4'hF};
        endcase
    endfunction

    assign sel_q = sample_q[SW-1:8];
    assign seg_q = sample_q[7:0];
`ifdef SEG7_DP_EN
    assign dec_pat = {1'b0, seg_q[6:0]};
`else
    assign dec_pat = seg_q;
`endif
    assign dec = decode(dec_pat);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        valid_d      = valid_q;
        seen_d       = seen_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;

        sample_d   = {bus.digsel, bus.segin};
        new_onehot = $onehot(bus.digsel);
        changed    = sample_d != sample_q;

        // A change seen during the commit cycle restarts settling at once.
        if (!new_onehot) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (state_q == IDLE || changed) begin
            cnt_d   = 4'd1;
            state_d = (cnt_d == STABLE_LIM) ? COMMIT : SETTLE;
        end else if (state_q == SETTLE) begin
            cnt_d   = 4'(cnt_q + 4'd1);
            state_d = (cnt_d == STABLE_LIM) ? COMMIT : SETTLE;
        end else begin
            state_d = HOLD;
        end

        if (state_q == COMMIT) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_q[i]) begin
                    bcd_d[i]   = dec[3:0];
                    valid_d[i] = dec[4];
                    dp_d[i]    = seg_q[7];
                end
            end
            if (!dec[4] && dec_pat != 8'h00) begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            seen_d = seen_q | sel_q;
            if (&seen_d) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end
        end
    end

    // The digit slots are a handful of flops and must read blank out of reset,
    // so they are reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            sample_q     <= '0;
            bcd_q        <= {DIGITS{4'hF}};
            valid_q      <= '0;
            seen_q       <= '0;
            dp_q         <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sample_q     <= sample_d;
            bcd_q        <= bcd_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bcdout      = bcd_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
`ifdef SEG7_DP_EN
    assign dpout       = dp_q;
`else
    logic unused_dp;
    assign unused_dp = ^dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (DIGITS=4, STABLE_CYCLES=3).
// Builds with or without SEG7_DP_EN; expectations follow the macro.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcdout;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic [7:0]  err_cnt;
`ifdef SEG7_DP_EN
    logic [3:0]  dpout;
`endif

    seg7_scan_if #(.DIGITS(4)) bus ();

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .bcdout      (bcdout),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_cnt     (err_cnt)
`ifdef SEG7_DP_EN
        ,
        .dpout       (dpout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;
    int err_pulses = 0;

    // Pulse counters sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (frame_done) frames++;
            if (err) err_pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  seg;
        int          hold;
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic [7:0]  ecnt;
        int          errs;
        int          frms;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
        bus.digsel = sel;
        bus.segin  = seg;
        repeat (n) @(negedge clk);
    endtask

    int fd0;
    int errs_exp;

    initial begin
        vecs[0]  = '{4'h1, 8'h7E,  5, 16'hFFF0, 4'h1, 8'd0, 0, 0};
        vecs[1]  = '{4'h2, 8'h30,  5, 16'hFF10, 4'h3, 8'd0, 0, 0};
        vecs[2]  = '{4'h4, 8'h79,  5, 16'hF310, 4'h7, 8'd0, 0, 0};
        vecs[3]  = '{4'h8, 8'h7B,  5, 16'h9310, 4'hF, 8'd0, 0, 1};
        vecs[4]  = '{4'h2, 8'h5B,  2, 16'h9310, 4'hF, 8'd0, 0, 1};
        vecs[5]  = '{4'h2, 8'h70,  4, 16'h9370, 4'hF, 8'd0, 0, 1};
        vecs[6]  = '{4'h6, 8'h30, 10, 16'h9370, 4'hF, 8'd0, 0, 1};
        vecs[7]  = '{4'h0, 8'h30,  3, 16'h9370, 4'hF, 8'd0, 0, 1};
        vecs[8]  = '{4'h4, 8'h01,  5, 16'h9F70, 4'hB, 8'd1, 1, 1};
        vecs[9]  = '{4'h8, 8'h00,  5, 16'hFF70, 4'h3, 8'd1, 1, 1};
`ifdef SEG7_DP_EN
        vecs[10] = '{4'h1, 8'hFF,  5, 16'hFF78, 4'h3, 8'd1, 1, 2};
`else
        vecs[10] = '{4'h1, 8'hFF,  5, 16'hFF7F, 4'h2, 8'd2, 2, 2};
`endif

        bus.digsel = 4'h0;
        bus.segin  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_bcdout", bcdout, 16'hFFFF);
        check("reset_valid", digit_valid, 4'h0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_err_cnt", err_cnt, 8'd0);
`ifdef SEG7_DP_EN
        check("reset_dpout", dpout, 4'h0);
`endif
        rst_n = 1'b1;

        // First commit: not visible after three edges, visible after the fourth.
        drive(4'h1, 8'h6D, 3);
        check("latency_early_bcd", bcdout, 16'hFFFF);
        check("latency_early_valid", digit_valid, 4'h0);
        drive(4'h1, 8'h6D, 1);
        check("first_commit_bcd", bcdout, 16'hFFF2);
        check("first_commit_valid", digit_valid, 4'h1);
        check("first_commit_no_frame", frames, 0);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].sel, vecs[i].seg, vecs[i].hold);
            check($sformatf("vec%0d_bcdout", i), bcdout, vecs[i].bcd);
            check($sformatf("vec%0d_valid", i), digit_valid, vecs[i].valid);
            check($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].ecnt);
            check($sformatf("vec%0d_err_pulses", i), err_pulses, vecs[i].errs);
            check($sformatf("vec%0d_frames", i), frames, vecs[i].frms);
        end
`ifdef SEG7_DP_EN
        check("dp_digit0", dpout, 4'h1);
`endif

        // Back-to-back errors on digit 2, each held exactly STABLE_CYCLES.
        for (int i = 0; i < 260; i++)
            drive(4'h4, (i % 2 == 0) ? 8'h01 : 8'h02, 3);
        drive(4'h0, 8'h00, 2);
        errs_exp = vecs[10].errs + 260;
        check("err_cnt_saturated", err_cnt, 8'd255);
        check("err_pulse_total", err_pulses, errs_exp);
        check("err_slot2_blank", bcdout[11:8], 4'hF);

        // Two commits, then an asynchronous reset mid-frame.
        drive(4'h1, 8'h7E, 4);
        drive(4'h2, 8'h30, 4);
        check("pre_reset_bcd", bcdout, 16'hFF10);
        check("pre_reset_valid", digit_valid, 4'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_bcd", bcdout, 16'hFFFF);
        check("async_reset_valid", digit_valid, 4'h0);
        check("async_reset_err_cnt", err_cnt, 8'd0);
        bus.digsel = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // Digits 2 and 3 alone must not complete a frame after the reset.
        fd0 = frames;
        drive(4'h4, 8'h6D, 4);
        drive(4'h8, 8'h5F, 4);
        check("no_stale_frame", frames, fd0);
        drive(4'h1, 8'h33, 4);
        drive(4'h2, 8'h70, 4);
        check("post_reset_one_frame", frames, fd0 + 1);
        check("post_reset_bcd", bcdout, 16'h6274);
        check("post_reset_valid", digit_valid, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
